series_result_collector: RTL and testbench

- Consumer end of the free-running series datapath register chain; the chain has no stall.
- Captures the last stage's sum/overflow whenever a result-valid token arrives and buffers the results in a DEPTH-entry FIFO.
- Presents buffered results downstream on a valid/ready interface.
- Issues admission credit to the upstream injector so that no result ever arrives when there is no slot for it.

---
 rtl/series_result_collector_if.sv | 30 +++
 rtl/series_result_collector.sv | 77 +++++++
 tb/tb_series_result_collector.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/series_result_collector_if.sv
// Result-collector signal bundle: injector credit, final-stage result capture,
// downstream valid/ready stream and status counters.
interface series_result_collector_if #(
  parameter int CW = 3
);
  logic          issue;
  logic          admit;
  logic          res_valid;
  logic [31:0]   res_sum;
  logic          res_overflow;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_sum;
  logic          out_overflow;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic          proto_err;

  // Collector side
  modport slave (
    input  issue, res_valid, res_sum, res_overflow, out_ready,
    output admit, out_valid, out_sum, out_overflow, count, inflight, proto_err
  );

  // Environment side: injector, final pipeline stage and downstream sink
  modport master (
    output issue, res_valid, res_sum, res_overflow, out_ready,
    input  admit, out_valid, out_sum, out_overflow, count, inflight, proto_err
  );
endinterface

// File: rtl/series_result_collector.sv
// Consumer end of the no-stall series datapath: buffers final-stage results in a
// DEPTH-entry first-word-fall-through FIFO and meters injector credit.
module series_result_collector #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  series_result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic          proto_err;
  logic [32:0]   mem [DEPTH];

  logic [CW:0]   occupancy;
  logic          admit;
  logic          out_valid;
  logic          full;
  logic          pop;
  logic          iss;
  logic          ret;
  logic          push;
  logic          violation;

  // Credit is checked against stored plus in-flight items so that a returning
  // result always finds a free slot in the FIFO.
  always_comb begin
    occupancy = {1'b0, count} + {1'b0, inflight};
    admit     = occupancy < DEPTH_W;
    out_valid = (count != '0);
    full      = ({1'b0, count} == DEPTH_W);
    pop       = out_valid & bus.out_ready;
    iss       = bus.issue & admit;
    ret       = bus.res_valid & (inflight != '0);
    push      = ret & (~full | pop);
    violation = (bus.issue & ~admit)
              | (bus.res_valid & (inflight == '0))
              | (bus.res_valid & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.res_overflow, bus.res_sum};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      inflight  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count + CW'(push) - CW'(pop);
      // A result dropped on a full FIFO still returns its credit.
      inflight  <= inflight + CW'(iss) - CW'(ret);
      proto_err <= proto_err | violation;
    end
  end

  assign bus.admit        = admit;
  assign bus.out_valid    = out_valid;
  assign bus.out_sum      = mem[rd_ptr][31:0];
  assign bus.out_overflow = mem[rd_ptr][32];
  assign bus.count        = count;
  assign bus.inflight     = inflight;
  assign bus.proto_err    = proto_err;
endmodule

// File: tb/tb_series_result_collector.sv
// Scenario bench for series_result_collector with a queue-based reference model.
module tb_series_result_collector;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk;
  logic rst;

  series_result_collector_if #(.CW(CW)) bus ();

  series_result_collector #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: stored results in order, outstanding credit, sticky error.
  logic [32:0] m_q[$];
  int          m_inf;
  bit          m_err;

  function automatic bit m_admit();
    return (m_q.size() + m_inf) < DEPTH;
  endfunction

  // Apply one clock edge to both the model and the DUT using current inputs.
  task automatic tick();
    bit vld, pop, adm, iss, push, ret;
    int sz;
    sz   = m_q.size();
    vld  = sz != 0;
    adm  = m_admit();
    pop  = vld && bus.out_ready;
    iss  = bus.issue && adm;
    ret  = bus.res_valid && m_inf != 0;
    push = ret && (sz < DEPTH || pop);
    if (rst) begin
      m_q.delete();
      m_inf = 0;
      m_err = 0;
    end else begin
      if (bus.issue && !adm) m_err = 1;
      if (bus.res_valid && m_inf == 0) m_err = 1;
      if (bus.res_valid && sz == DEPTH && !pop) m_err = 1;
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({bus.res_overflow, bus.res_sum});
      m_inf = m_inf + int'(iss) - int'(ret);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue        = 1'b0;
    bus.res_valid    = 1'b0;
    bus.res_sum      = '0;
    bus.res_overflow = 1'b0;
    bus.out_ready    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.issue = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.issue = 1'b0;
    #1;
    n_vec++; if (bus.admit !== 1'b1) begin n_err++; $display("FAIL reset_admit: got %b want 1", bus.admit); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_vec++; if (bus.inflight !== 3'd0) begin n_err++; $display("FAIL reset_inflight: got %0d want 0", bus.inflight); end
    n_vec++; if (bus.proto_err !== 1'b0) begin n_err++; $display("FAIL reset_proto_err: got %b want 0", bus.proto_err); end
  endtask

  task automatic test_single();
    idle_inputs();
    bus.out_ready = 1'b1;
    bus.issue = 1'b1;
    tick();
    bus.issue = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin
        bus.res_valid = 1'b1;
        bus.res_sum   = 32'h0000_1234;
      end
      #1;
      n_vec++; if (bus.inflight !== 3'd1) begin n_err++; $display("FAIL single_inflight_c%0d: got %0d want 1", c, bus.inflight); end
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid_c%0d: got %b want 0", c, bus.out_valid); end
      tick();
    end
    idle_inputs();
    bus.out_ready = 1'b1;
    #1;
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
    n_vec++; if (bus.out_sum !== 32'h0000_1234) begin n_err++; $display("FAIL single_sum: got %h want 00001234", bus.out_sum); end
    n_vec++; if (bus.inflight !== 3'd0) begin n_err++; $display("FAIL single_inflight_done: got %0d want 0", bus.inflight); end
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_after: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL single_count_after: got %0d want 0", bus.count); end
  endtask

  task automatic test_credit();
    do_reset();
    bus.issue = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    #1;
    n_vec++; if (bus.admit !== 1'b0) begin n_err++; $display("FAIL credit_admit: got %b want 0", bus.admit); end
    n_vec++; if (bus.proto_err !== 1'b0) begin n_err++; $display("FAIL credit_err_early: got %b want 0", bus.proto_err); end
    tick();
    bus.issue = 1'b0;
    #1;
    n_vec++; if (bus.proto_err !== 1'b1) begin n_err++; $display("FAIL credit_err: got %b want 1", bus.proto_err); end
    n_vec++; if (bus.inflight !== 3'd4) begin n_err++; $display("FAIL credit_inflight: got %0d want 4", bus.inflight); end
    for (int i = 1; i <= DEPTH; i++) begin
      bus.res_valid    = 1'b1;
      bus.res_sum      = 32'(i);
      bus.res_overflow = (i == 3);
      tick();
    end
    idle_inputs();
    #1;
    n_vec++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL credit_count: got %0d want 4", bus.count); end
    n_vec++; if (bus.inflight !== 3'd0) begin n_err++; $display("FAIL credit_inflight_ret: got %0d want 0", bus.inflight); end
    bus.out_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      #1;
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 32'(i)) begin n_err++; $display("FAIL credit_drain_%0d: got v=%b sum=%0d want v=1 sum=%0d", i, bus.out_valid, bus.out_sum, i); end
      n_vec++; if (bus.out_overflow !== (i == 3)) begin n_err++; $display("FAIL credit_ovf_%0d: got %b want %b", i, bus.out_overflow, (i == 3)); end
      tick();
    end
    n_vec++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL credit_empty: got %0d want 0", bus.count); end
  endtask

  task automatic test_full_pushpop();
    int sum;
    do_reset();
    bus.issue = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    bus.issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.res_valid = 1'b1;
      bus.res_sum   = 32'(100 + i);
      tick();
    end
    bus.out_ready = 1'b1;
    bus.res_sum   = 32'd9;
    #1;
    n_vec++; if (bus.count !== 3'd3 || bus.inflight !== 3'd1) begin n_err++; $display("FAIL pp_setup: got count=%0d inflight=%0d want 3 1", bus.count, bus.inflight); end
    tick();
    bus.res_valid = 1'b0;
    #1;
    n_vec++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL pp_count: got %0d want 3", bus.count); end
    n_vec++; if (bus.out_sum !== 32'd101) begin n_err++; $display("FAIL pp_head: got %0d want 101", bus.out_sum); end
    // Steady stream: every issue is returned later while the sink drains.
    sum = 200;
    for (int c = 0; c < 20; c++) begin
      bus.issue     = m_admit();
      bus.res_valid = (m_inf != 0);
      bus.res_sum   = 32'(sum);
      if (m_inf != 0) sum++;
      #1;
      n_vec++; if (bus.count !== CW'(m_q.size())) begin n_err++; $display("FAIL pp_stream_count_%0d: got %0d want %0d", c, bus.count, m_q.size()); end
      if (m_q.size() != 0) begin
        n_vec++; if (bus.out_sum !== m_q[0][31:0]) begin n_err++; $display("FAIL pp_stream_head_%0d: got %0d want %0d", c, bus.out_sum, m_q[0][31:0]); end
      end
      tick();
    end
    idle_inputs();
    n_vec++; if (bus.proto_err !== 1'b0) begin n_err++; $display("FAIL pp_err: got %b want 0", bus.proto_err); end
  endtask

  task automatic test_stray();
    do_reset();
    bus.res_valid = 1'b1;
    bus.res_sum   = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    #1;
    n_vec++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL stray_count: got %0d want 0", bus.count); end
    n_vec++; if (bus.proto_err !== 1'b1) begin n_err++; $display("FAIL stray_err: got %b want 1", bus.proto_err); end
    do_reset();
    #1;
    n_vec++; if (bus.proto_err !== 1'b0) begin n_err++; $display("FAIL stray_err_clear: got %b want 0", bus.proto_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.issue = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    bus.issue = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.res_valid = 1'b1;
      bus.res_sum   = 32'(50 + i);
      tick();
    end
    idle_inputs();
    #1;
    n_vec++; if (bus.count !== 3'd2 || bus.inflight !== 3'd2) begin n_err++; $display("FAIL mid_setup: got count=%0d inflight=%0d want 2 2", bus.count, bus.inflight); end
    do_reset();
    #1;
    n_vec++; if (bus.count !== 3'd0 || bus.inflight !== 3'd0) begin n_err++; $display("FAIL mid_counters: got count=%0d inflight=%0d want 0 0", bus.count, bus.inflight); end
    n_vec++; if (bus.out_valid !== 1'b0 || bus.admit !== 1'b1) begin n_err++; $display("FAIL mid_flags: got valid=%b admit=%b want 0 1", bus.out_valid, bus.admit); end
    bus.res_valid = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_vec++; if (bus.proto_err !== 1'b1) begin n_err++; $display("FAIL mid_late_err: got %b want 1", bus.proto_err); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      // Mostly legal traffic with occasional protocol violations.
      bus.issue        = ($urandom_range(0, 19) == 0) ? 1'b1 : (m_admit() && $urandom_range(0, 1));
      bus.res_valid    = ($urandom_range(0, 29) == 0) ? 1'b1 : ((m_inf != 0) && $urandom_range(0, 2) != 0);
      bus.res_sum      = $urandom;
      bus.res_overflow = $urandom_range(0, 1);
      bus.out_ready    = ($urandom_range(0, 3) != 0);
      if (c % 97 == 96) rst = 1'b1;
      #1;
      n_vec++; if (bus.admit !== m_admit()) begin n_err++; $display("FAIL rnd_admit_%0d: got %b want %b", c, bus.admit, m_admit()); end
      n_vec++; if (bus.out_valid !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd_valid_%0d: got %b want %b", c, bus.out_valid, m_q.size() != 0); end
      n_vec++; if (bus.count !== CW'(m_q.size())) begin n_err++; $display("FAIL rnd_count_%0d: got %0d want %0d", c, bus.count, m_q.size()); end
      n_vec++; if (bus.inflight !== CW'(m_inf)) begin n_err++; $display("FAIL rnd_inflight_%0d: got %0d want %0d", c, bus.inflight, m_inf); end
      n_vec++; if (bus.proto_err !== m_err) begin n_err++; $display("FAIL rnd_err_%0d: got %b want %b", c, bus.proto_err, m_err); end
      if (m_q.size() != 0) begin
        n_vec++; if ({bus.out_overflow, bus.out_sum} !== m_q[0]) begin n_err++; $display("FAIL rnd_head_%0d: got %h want %h", c, {bus.out_overflow, bus.out_sum}, m_q[0]); end
      end
      tick();
      rst = 1'b0;
    end
    idle_inputs();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_inf = 0;
    m_err = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_credit();
    test_full_pushpop();
    test_stray();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
